// File: rtl/sobel_pkg.sv
// Shared types and constants for the 3x3 Sobel edge detector.
package sobel_pkg;

   localparam int unsigned DATA_W = 12;
   localparam int unsigned GRAD_W = DATA_W + 4;
   localparam int unsigned CNT_W  = 16;

   typedef logic [DATA_W-1:0]        pixel_t;
   typedef logic signed [GRAD_W-1:0] grad_t;
   typedef logic [CNT_W-1:0]         coord_t;

   // Sobel kernel weights: outer taps and the centre tap of each row/column
   localparam grad_t K_SIDE = grad_t'(1);
   localparam grad_t K_MID  = grad_t'(2);

   // Zero-extend a pixel into the signed gradient domain
   function automatic grad_t to_grad(input pixel_t p);
      return grad_t'({{(GRAD_W-DATA_W){1'b0}}, p});
   endfunction

endpackage

// File: rtl/sobel_edge_3x3_if.sv
// Pixel stream in / gradient stream out of the Sobel block.
interface sobel_edge_3x3_if;
   import sobel_pkg::*;

   pixel_t iDATA;
   logic   iDVAL;
   logic   iFRAME_START;
   logic   iBYPASS;
   pixel_t oDATA;
   logic   oDVAL;
   coord_t oCOL;
   coord_t oROW;

   modport master (
      output iDATA, iDVAL, iFRAME_START, iBYPASS,
      input  oDATA, oDVAL, oCOL, oROW
   );

   modport slave (
      input  iDATA, iDVAL, iFRAME_START, iBYPASS,
      output oDATA, oDVAL, oCOL, oROW
   );

endinterface

// File: rtl/sobel_line_buffer.sv
// Two cascaded line stores sharing one column address, read-before-write.
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter int unsigned DEPTH = 640,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          iCLK,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  pixel_t        wdata_i,
   output pixel_t        rd0_c_o,
   output pixel_t        rd1_c_o
);

   pixel_t lb0_q [DEPTH];
   pixel_t lb1_q [DEPTH];

   // Old contents are visible in the same cycle as the write
   assign rd0_c_o = lb0_q[addr_i];
   assign rd1_c_o = lb1_q[addr_i];

   // New pixel enters row 0; the displaced row-0 pixel moves down to row 1
   always_ff @(posedge iCLK) begin
      if (we_i) begin
         lb0_q[addr_i] <= wdata_i;
         lb1_q[addr_i] <= lb0_q[addr_i];
      end
   end

endmodule

// File: rtl/sobel_edge_3x3.sv
// Streaming 3x3 Sobel gradient magnitude with bypass and fixed 3-cycle latency.
module sobel_edge_3x3
   import sobel_pkg::*;
#(
   parameter int unsigned LINE_W  = 640,
   parameter int unsigned FRAME_H = 480,
   parameter int unsigned SHIFT   = 2
) (
   input logic             iCLK,
   input logic             iRST,
   sobel_edge_3x3_if.slave bus
);

   localparam int unsigned AW      = $clog2(LINE_W);
   localparam pixel_t      PIX_MAX = '1;

   coord_t col_q, row_q, col_d, row_d, col_eff, row_eff;
   pixel_t lb0_rd, lb1_rd;
   pixel_t win_q [3][3];

   logic   v1_q, byp1_q, bord1_q;
   coord_t ocol1_q, orow1_q;
   logic   v2_q, byp2_q, bord2_q;
   coord_t ocol2_q, orow2_q;
   pixel_t cen2_q;
   grad_t  gx2_q, gy2_q, gx_c, gy_c;

   logic [GRAD_W-1:0] ax_c, ay_c, mag_c, shr_c;
   pixel_t            res_c;

   logic   odval_q;
   pixel_t odata_q;
   coord_t ocol_q, orow_q;

   // Column/row position of the incoming pixel and the counters' next value
   always_comb begin
      col_eff = bus.iFRAME_START ? '0 : col_q;
      row_eff = bus.iFRAME_START ? '0 : row_q;
      col_d   = col_eff;
      row_d   = row_eff;
      if (bus.iDVAL) begin
         if (col_eff == coord_t'(LINE_W - 1)) begin
            col_d = '0;
            row_d = (row_eff == coord_t'(FRAME_H - 1)) ? '0 : row_eff + coord_t'(1);
         end else begin
            col_d = col_eff + coord_t'(1);
         end
      end
   end

   sobel_line_buffer #(.DEPTH(LINE_W), .AW(AW)) u_lb (
      .iCLK    (iCLK),
      .we_i    (bus.iDVAL),
      .addr_i  (col_eff[AW-1:0]),
      .wdata_i (bus.iDATA),
      .rd0_c_o (lb0_rd),
      .rd1_c_o (lb1_rd)
   );

   // Window shift: new right column is {two lines up, one line up, current}
   always_ff @(posedge iCLK) begin
      if (bus.iDVAL) begin
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= win_q[r][2];
         end
         win_q[0][2] <= lb1_rd;
         win_q[1][2] <= lb0_rd;
         win_q[2][2] <= bus.iDATA;
      end
   end

   // Horizontal and vertical gradients of the current window
   always_comb begin
      gx_c = (to_grad(win_q[0][2]) * K_SIDE + to_grad(win_q[1][2]) * K_MID
              + to_grad(win_q[2][2]) * K_SIDE)
           - (to_grad(win_q[0][0]) * K_SIDE + to_grad(win_q[1][0]) * K_MID
              + to_grad(win_q[2][0]) * K_SIDE);
      gy_c = (to_grad(win_q[2][0]) * K_SIDE + to_grad(win_q[2][1]) * K_MID
              + to_grad(win_q[2][2]) * K_SIDE)
           - (to_grad(win_q[0][0]) * K_SIDE + to_grad(win_q[0][1]) * K_MID
              + to_grad(win_q[0][2]) * K_SIDE);
   end

   // Magnitude, scaling, saturation and the bypass/border output select
   always_comb begin
      ax_c  = gx2_q[GRAD_W-1] ? -gx2_q : gx2_q;
      ay_c  = gy2_q[GRAD_W-1] ? -gy2_q : gy2_q;
      mag_c = ax_c + ay_c;
      shr_c = mag_c >> SHIFT;
      res_c = (|shr_c[GRAD_W-1:DATA_W]) ? PIX_MAX : shr_c[DATA_W-1:0];
      if (bord2_q) res_c = '0;
      if (byp2_q)  res_c = cen2_q;
   end

   // Counters, pipeline tags, gradient stage and output registers
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         col_q   <= '0;
         row_q   <= '0;
         v1_q    <= 1'b0;
         byp1_q  <= 1'b0;
         bord1_q <= 1'b0;
         ocol1_q <= '0;
         orow1_q <= '0;
         v2_q    <= 1'b0;
         byp2_q  <= 1'b0;
         bord2_q <= 1'b0;
         ocol2_q <= '0;
         orow2_q <= '0;
         cen2_q  <= '0;
         gx2_q   <= '0;
         gy2_q   <= '0;
         odval_q <= 1'b0;
         odata_q <= '0;
         ocol_q  <= '0;
         orow_q  <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         v1_q  <= bus.iDVAL;
         if (bus.iDVAL) begin
            byp1_q  <= bus.iBYPASS;
            bord1_q <= (row_eff < coord_t'(2)) || (col_eff < coord_t'(2));
            ocol1_q <= (col_eff == '0) ? coord_t'(LINE_W - 1) : col_eff - coord_t'(1);
            orow1_q <= (row_eff == '0) ? coord_t'(FRAME_H - 1) : row_eff - coord_t'(1);
         end
         v2_q <= v1_q;
         if (v1_q) begin
            byp2_q  <= byp1_q;
            bord2_q <= bord1_q;
            ocol2_q <= ocol1_q;
            orow2_q <= orow1_q;
            cen2_q  <= win_q[1][1];
            gx2_q   <= gx_c;
            gy2_q   <= gy_c;
         end
         odval_q <= v2_q;
         if (v2_q) begin
            odata_q <= res_c;
            ocol_q  <= ocol2_q;
            orow_q  <= orow2_q;
         end
      end
   end

   assign bus.oDATA = odata_q;
   assign bus.oDVAL = odval_q;
   assign bus.oCOL  = ocol_q;
   assign bus.oROW  = orow_q;

endmodule

// File: tb/tb_sobel_edge_3x3.sv
// Bench for sobel_edge_3x3: window vector table plus scoreboarded frame sequences.
module tb_sobel_edge_3x3;
   import sobel_pkg::*;

   localparam int unsigned LW = 8;
   localparam int unsigned FH = 6;
   localparam int unsigned SH = 2;

   logic iCLK = 1'b0;
   logic iRST;

   sobel_edge_3x3_if bus ();

   sobel_edge_3x3 #(.LINE_W(LW), .FRAME_H(FH), .SHIFT(SH)) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus)
   );

   always #5 iCLK = ~iCLK;

   typedef struct packed {
      pixel_t data;
      coord_t col;
      coord_t row;
      logic   chk;
      int     cyc;
   } exp_t;

   typedef struct packed {
      pixel_t tl, tc, tr, ml, mc, mr, bl, bc, br;
      logic   byp;
      pixel_t expv;
   } vec_t;

   exp_t   sb[$];
   int     total = 0;
   int     bad   = 0;
   int     cyc   = 0;
   pixel_t img [FH][LW];
   int     r_m = 0;
   int     c_m = 0;

   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int grad_model(input int r, input int c);
      int w[3][3];
      int gx, gy, m;
      if (r < 2 || c < 2) return 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[i][j] = int'(img[r-2+i][c-2+j]);
      gx = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
      gy = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
      m  = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) >> SH;
      return (m > 4095) ? 4095 : m;
   endfunction

   function automatic vec_t mk(input int tl, tc, tr, ml, mc, mr, bl, bc, br,
                               input bit byp, input int expv);
      vec_t v;
      v.tl = pixel_t'(tl); v.tc = pixel_t'(tc); v.tr = pixel_t'(tr);
      v.ml = pixel_t'(ml); v.mc = pixel_t'(mc); v.mr = pixel_t'(mr);
      v.bl = pixel_t'(bl); v.bc = pixel_t'(bc); v.br = pixel_t'(br);
      v.byp = byp; v.expv = pixel_t'(expv);
      return v;
   endfunction

   task automatic idle();
      bus.iDVAL        = 1'b0;
      bus.iFRAME_START = 1'b0;
      bus.iDATA        = pixel_t'($urandom);
      @(posedge iCLK); #1;
   endtask

   task automatic fs_pulse();
      bus.iFRAME_START = 1'b1;
      bus.iDVAL        = 1'b0;
      @(posedge iCLK); #1;
      bus.iFRAME_START = 1'b0;
      r_m = 0; c_m = 0;
   endtask

   // Drive one pixel; fixed_exp < 0 means use the gradient model
   task automatic drive_pix(input pixel_t d, input bit fs, input bit byp,
                            input int fixed_exp, input bit chk_d);
      exp_t e;
      if (fs) begin r_m = 0; c_m = 0; end
      img[r_m][c_m] = d;
      e.col  = coord_t'((c_m + LW - 1) % LW);
      e.row  = coord_t'((r_m + FH - 1) % FH);
      e.chk  = chk_d;
      e.cyc  = cyc;
      e.data = (fixed_exp >= 0) ? pixel_t'(fixed_exp) : pixel_t'(grad_model(r_m, c_m));
      sb.push_back(e);
      bus.iDATA        = d;
      bus.iDVAL        = 1'b1;
      bus.iFRAME_START = fs;
      bus.iBYPASS      = byp;
      @(posedge iCLK); #1;
      bus.iDVAL        = 1'b0;
      bus.iFRAME_START = 1'b0;
      bus.iBYPASS      = 1'b0;
      if (c_m == LW - 1) begin
         c_m = 0;
         r_m = (r_m == FH - 1) ? 0 : r_m + 1;
      end else begin
         c_m++;
      end
   endtask

   // Output monitor: pop and compare one expectation per oDVAL
   always @(negedge iCLK) begin
      exp_t e;
      if (iRST === 1'b0 && bus.oDVAL === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_dval: got oDVAL=1 required no pending output (t=%0t)", $time);
         end else begin
            e = sb.pop_front();
            if (e.chk) chk("odata", int'(bus.oDATA), int'(e.data));
            chk("ocol", int'(bus.oCOL), int'(e.col));
            chk("orow", int'(bus.oROW), int'(e.row));
            chk("latency", cyc - e.cyc, 3);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish required finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[9];
      int   w[3][3];
      pixel_t d;

      tbl[0] = mk(4095, 4095, 0, 4095, 0, 0, 0, 0, 0,       1'b0, 4095);
      tbl[1] = mk(500, 500, 500, 500, 500, 500, 500, 500, 500, 1'b0, 0);
      tbl[2] = mk(0, 0, 4095, 0, 0, 4095, 0, 0, 4095,       1'b0, 4095);
      tbl[3] = mk(0, 0, 100, 0, 0, 0, 0, 0, 0,              1'b0, 50);
      tbl[4] = mk(0, 0, 0, 0, 0, 40, 0, 0, 0,               1'b0, 20);
      tbl[5] = mk(0, 0, 0, 0, 0, 0, 0, 7, 0,                1'b0, 3);
      tbl[6] = mk(0, 0, 0, 0, 1234, 0, 0, 0, 0,             1'b0, 0);
      tbl[7] = mk(0, 0, 0, 0, 1234, 0, 0, 0, 0,             1'b1, 1234);
      tbl[8] = mk(0, 0, 1000, 0, 0, 0, 3000, 0, 0,          1'b0, 1000);

      iRST             = 1'b1;
      bus.iDATA        = '0;
      bus.iDVAL        = 1'b0;
      bus.iFRAME_START = 1'b0;
      bus.iBYPASS      = 1'b0;
      repeat (2) @(posedge iCLK);
      @(negedge iCLK);
      chk("rst_odval", int'(bus.oDVAL), 0);
      chk("rst_odata", int'(bus.oDATA), 0);
      chk("rst_ocol",  int'(bus.oCOL),  0);
      chk("rst_orow",  int'(bus.oROW),  0);
      @(posedge iCLK); #1;
      iRST = 1'b0;
      idle();

      // Single-window vectors completed at pixel (2,2) of a 3-row frame
      for (int k = 0; k < 9; k++) begin
         w[0][0] = int'(tbl[k].tl); w[0][1] = int'(tbl[k].tc); w[0][2] = int'(tbl[k].tr);
         w[1][0] = int'(tbl[k].ml); w[1][1] = int'(tbl[k].mc); w[1][2] = int'(tbl[k].mr);
         w[2][0] = int'(tbl[k].bl); w[2][1] = int'(tbl[k].bc); w[2][2] = int'(tbl[k].br);
         fs_pulse();
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < int'(LW); c++) begin
               d = (c < 3) ? pixel_t'(w[r][c]) : '0;
               if (r == 2 && c == 2) drive_pix(d, 1'b0, tbl[k].byp, int'(tbl[k].expv), 1'b1);
               else                  drive_pix(d, 1'b0, 1'b0, -1, 1'b1);
            end
         repeat (4) idle();
      end

      // Flat frame: no gradient anywhere; frame start coincides with first pixel
      for (int n = 0; n < int'(LW*FH); n++)
         drive_pix(pixel_t'(100), n == 0, 1'b0, -1, 1'b1);
      repeat (4) idle();

      // Vertical edge, contiguous
      for (int n = 0; n < int'(LW*FH); n++)
         drive_pix(((n % LW) < 4) ? pixel_t'(0) : pixel_t'(4095), n == 0, 1'b0, -1, 1'b1);
      repeat (4) idle();

      // Vertical edge, sparse with random gaps
      for (int n = 0; n < int'(LW*FH); n++) begin
         drive_pix(((n % LW) < 4) ? pixel_t'(0) : pixel_t'(4095), n == 0, 1'b0, -1, 1'b1);
         repeat (2 + $urandom_range(0, 2)) idle();
      end
      repeat (4) idle();

      // Bypass ramp over two frames: centre is the pixel one line plus one earlier
      for (int n = 0; n < int'(2*LW*FH); n++)
         drive_pix(pixel_t'(n), (n % (LW*FH)) == 0, 1'b1, (n >= 9) ? n - 9 : 0, n >= 9);
      repeat (4) idle();

      // Reset mid-line after pixel 13: in-flight pixels are dropped
      fs_pulse();
      for (int n = 0; n < 13; n++)
         drive_pix(pixel_t'($urandom), 1'b0, 1'b0, -1, 1'b1);
      iRST = 1'b1;
      sb.delete();
      repeat (2) begin
         @(negedge iCLK);
         chk("midrst_odval", int'(bus.oDVAL), 0);
         chk("midrst_odata", int'(bus.oDATA), 0);
         chk("midrst_ocol",  int'(bus.oCOL),  0);
         chk("midrst_orow",  int'(bus.oROW),  0);
         @(posedge iCLK); #1;
      end
      iRST = 1'b0;
      r_m = 0; c_m = 0;
      for (int n = 0; n < int'(3*LW); n++)
         drive_pix(pixel_t'($urandom), 1'b0, 1'b0, -1, 1'b1);
      repeat (6) idle();

      chk("pending_at_end", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
